fmul_normalize_round_pipe: RTL and testbench



---
 rtl/fmul_normalize_round_pipe.sv | 142 ++++++++++++++
 tb/tb_fmul_normalize_round_pipe.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fmul_normalize_round_pipe.sv
// Two-stage normalize-and-round for the FP multiplier: stage 1 aligns the raw
// mantissa product and extracts guard/sticky, stage 2 rounds and renormalizes.
module fmul_normalize_round_pipe #(
  parameter int unsigned P_MANT_W = 60,
  parameter int unsigned P_EXP_W  = 13
) (
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  input  logic                    iRESET_SYNC,
  input  logic                    iDATA_VALID,
  output logic                    oDATA_BUSY,
  input  logic                    iDATA_SIGN,
  input  logic [P_EXP_W-1:0]      iDATA_EXP,
  input  logic [2*P_MANT_W-1:0]   iDATA_FRACT,
  input  logic [1:0]              iDATA_RMODE,
  input  logic [5:0]              iDATA_EXCEPT,
  output logic                    oDATA_VALID,
  input  logic                    iDATA_BUSY,
  output logic                    oDATA_SIGN,
  output logic [P_EXP_W-1:0]      oDATA_EXP,
  output logic [P_MANT_W-1:0]     oDATA_FRACT,
  output logic                    oDATA_INEXACT,
  output logic                    oDATA_OVF,
  output logic [5:0]              oDATA_EXCEPT
);

  localparam int unsigned M  = P_MANT_W;
  localparam int unsigned E  = P_EXP_W;
  localparam int unsigned PW = 2 * P_MANT_W;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RUP = 2'd2,
    RM_RDN = 2'd3
  } rmode_e;

  typedef struct packed {
    logic         valid;
    logic         sign;
    rmode_e       rmode;
    logic [5:0]   except;
    logic [E-1:0] exp;
    logic         ovf;
    logic [M-1:0] mant;
    logic         g;
    logic         st;
  } s1_t;

  typedef struct packed {
    logic         valid;
    logic         sign;
    logic [E-1:0] exp;
    logic [M-1:0] fract;
    logic         inexact;
    logic         ovf;
    logic [5:0]   except;
  } s2_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;

  logic [E:0]   exp1_sum;
  logic         inc;
  logic [M:0]   rnd_sum;
  logic         rnd_carry;
  logic [E:0]   exp2_sum;
  logic         ovf2;

  assign oDATA_BUSY = iDATA_BUSY;

  // Stage 1: shift the product so the hidden 1 lands in the mantissa MSB.
  always_comb begin
    s1_d     = s1_q;
    exp1_sum = {1'b0, iDATA_EXP} + (E+1)'(iDATA_FRACT[PW-1]);
    if (!iDATA_BUSY) begin
      s1_d.valid  = iDATA_VALID;
      s1_d.sign   = iDATA_SIGN;
      s1_d.rmode  = rmode_e'(iDATA_RMODE);
      s1_d.except = iDATA_EXCEPT;
      s1_d.exp    = exp1_sum[E-1:0];
      s1_d.ovf    = exp1_sum[E];
      if (iDATA_FRACT[PW-1]) begin
        s1_d.mant = iDATA_FRACT[PW-1 -: M];
        s1_d.g    = iDATA_FRACT[M-1];
        s1_d.st   = |iDATA_FRACT[M-2:0];
      end else begin
        s1_d.mant = iDATA_FRACT[PW-2 -: M];
        s1_d.g    = iDATA_FRACT[M-2];
        s1_d.st   = |iDATA_FRACT[M-3:0];
      end
    end
  end

  // Stage 2: mode-dependent increment, carry-out renormalization, saturation.
  always_comb begin
    s2_d = s2_q;
    inc  = 1'b0;
    unique case (s1_q.rmode)
      RM_RNE: inc = s1_q.g & (s1_q.mant[0] | s1_q.st);
      RM_RTZ: inc = 1'b0;
      RM_RUP: inc = ~s1_q.sign & (s1_q.g | s1_q.st);
      RM_RDN: inc = s1_q.sign & (s1_q.g | s1_q.st);
      default: inc = 1'b0;
    endcase
    rnd_sum   = {1'b0, s1_q.mant} + (M+1)'(inc);
    rnd_carry = rnd_sum[M];
    exp2_sum  = {1'b0, s1_q.exp} + (E+1)'(rnd_carry);
    ovf2      = s1_q.ovf | exp2_sum[E];
    if (!iDATA_BUSY) begin
      s2_d.valid   = s1_q.valid;
      s2_d.sign    = s1_q.sign;
      s2_d.fract   = rnd_carry ? rnd_sum[M:1] : rnd_sum[M-1:0];
      s2_d.exp     = ovf2 ? {E{1'b1}} : exp2_sum[E-1:0];
      s2_d.inexact = s1_q.g | s1_q.st;
      s2_d.ovf     = ovf2;
      s2_d.except  = s1_q.except;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (iRESET_SYNC) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign oDATA_VALID   = s2_q.valid;
  assign oDATA_SIGN    = s2_q.sign;
  assign oDATA_EXP     = s2_q.exp;
  assign oDATA_FRACT   = s2_q.fract;
  assign oDATA_INEXACT = s2_q.inexact;
  assign oDATA_OVF     = s2_q.ovf;
  assign oDATA_EXCEPT  = s2_q.except;

endmodule

// File: tb/tb_fmul_normalize_round_pipe.sv
// Directed bench for fmul_normalize_round_pipe with an 8-bit mantissa instance.
module tb_fmul_normalize_round_pipe;

  localparam int unsigned M = 8;
  localparam int unsigned E = 13;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           sync_rst;
  logic           in_valid;
  logic           out_busy;
  logic           in_sign;
  logic [E-1:0]   in_exp;
  logic [2*M-1:0] in_fract;
  logic [1:0]     in_rmode;
  logic [5:0]     in_except;
  logic           out_valid;
  logic           busy;
  logic           out_sign;
  logic [E-1:0]   out_exp;
  logic [M-1:0]   out_fract;
  logic           out_inexact;
  logic           out_ovf;
  logic [5:0]     out_except;

  always #5 clk = ~clk;

  fmul_normalize_round_pipe #(.P_MANT_W(M), .P_EXP_W(E)) dut (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(sync_rst),
    .iDATA_VALID(in_valid), .oDATA_BUSY(out_busy), .iDATA_SIGN(in_sign),
    .iDATA_EXP(in_exp), .iDATA_FRACT(in_fract), .iDATA_RMODE(in_rmode),
    .iDATA_EXCEPT(in_except), .oDATA_VALID(out_valid), .iDATA_BUSY(busy),
    .oDATA_SIGN(out_sign), .oDATA_EXP(out_exp), .oDATA_FRACT(out_fract),
    .oDATA_INEXACT(out_inexact), .oDATA_OVF(out_ovf), .oDATA_EXCEPT(out_except)
  );

  typedef struct {
    logic           sign;
    logic [E-1:0]   exp;
    logic [2*M-1:0] fract;
    logic [1:0]     rmode;
    logic [5:0]     exc;
    logic [E-1:0]   exp_o;
    logic [M-1:0]   fract_o;
    logic           inexact_o;
    logic           ovf_o;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [E-1:0] e, input logic [2*M-1:0] f,
                              input logic [1:0] rm, input logic [5:0] x, input logic [E-1:0] eo,
                              input logic [M-1:0] fo, input logic ix, input logic ov);
    vec_t v;
    v.sign = s; v.exp = e; v.fract = f; v.rmode = rm; v.exc = x;
    v.exp_o = eo; v.fract_o = fo; v.inexact_o = ix; v.ovf_o = ov;
    return v;
  endfunction

  function automatic logic [31:0] all_out();
    return 32'({out_valid, out_sign, out_exp, out_fract, out_inexact, out_ovf, out_except});
  endfunction

  task automatic drive(input logic v, input logic s, input logic [E-1:0] e,
                       input logic [2*M-1:0] f, input logic [1:0] rm, input logic [5:0] x);
    in_valid = v; in_sign = s; in_exp = e; in_fract = f; in_rmode = rm; in_except = x;
  endtask

  logic [E-1:0] got_exp [$];
  logic [M-1:0] got_fract [$];
  logic [31:0]  snap;
  int           k;

  initial begin
    // sign, exp, fract, rmode, except -> exp_o, fract_o, inexact, ovf
    vecs[0]  = mk(0, 13'h0100, 16'h8000, 2'd0, 6'h00, 13'h0101, 8'h80, 0, 0);
    vecs[1]  = mk(0, 13'h0100, 16'h4140, 2'd0, 6'h01, 13'h0100, 8'h82, 1, 0);
    vecs[2]  = mk(0, 13'h0100, 16'h4140, 2'd2, 6'h02, 13'h0100, 8'h83, 1, 0);
    vecs[3]  = mk(1, 13'h0100, 16'h4140, 2'd3, 6'h04, 13'h0100, 8'h83, 1, 0);
    vecs[4]  = mk(0, 13'h0100, 16'h4140, 2'd1, 6'h08, 13'h0100, 8'h82, 1, 0);
    vecs[5]  = mk(0, 13'h0100, 16'h41C0, 2'd0, 6'h10, 13'h0100, 8'h84, 1, 0);
    vecs[6]  = mk(0, 13'h0100, 16'h7FC0, 2'd0, 6'h20, 13'h0101, 8'h80, 1, 0);
    vecs[7]  = mk(0, 13'h1FFF, 16'h8000, 2'd0, 6'b101010, 13'h1FFF, 8'h80, 0, 1);
    vecs[8]  = mk(1, 13'h0055, 16'h0000, 2'd0, 6'h3F, 13'h0055, 8'h00, 0, 0);
    vecs[9]  = mk(0, 13'h0100, 16'h4140, 2'd3, 6'h15, 13'h0100, 8'h82, 1, 0);
    vecs[10] = mk(0, 13'h0100, 16'h80C1, 2'd0, 6'h00, 13'h0101, 8'h81, 1, 0);
    vecs[11] = mk(1, 13'h0100, 16'h4140, 2'd2, 6'h2A, 13'h0100, 8'h82, 1, 0);

    rst_n = 1'b0; sync_rst = 1'b0; busy = 1'b0;
    drive(0, 0, '0, '0, 2'd0, '0);
    #12;
    chk("reset outputs", all_out(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Isolated beats: drive on a falling edge, result two rising edges later.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(1, vecs[i].sign, vecs[i].exp, vecs[i].fract, vecs[i].rmode, vecs[i].exc);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d valid", i),   32'(out_valid),   32'h1);
      chk($sformatf("v%0d fract", i),   32'(out_fract),   32'(vecs[i].fract_o));
      chk($sformatf("v%0d exp", i),     32'(out_exp),     32'(vecs[i].exp_o));
      chk($sformatf("v%0d inexact", i), 32'(out_inexact), 32'(vecs[i].inexact_o));
      chk($sformatf("v%0d ovf", i),     32'(out_ovf),     32'(vecs[i].ovf_o));
      chk($sformatf("v%0d sign", i),    32'(out_sign),    32'(vecs[i].sign));
      chk($sformatf("v%0d except", i),  32'(out_except),  32'(vecs[i].exc));
    end

    // Stall: four back-to-back beats, downstream busy for three cycles mid-stream.
    k = 0;
    snap = '0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      busy = (c >= 2 && c < 5);
      if (k < 4) drive(1, 0, E'(13'h10 + k), 16'(16'h8000 + k * 16'h0100), 2'd1, 6'(k));
      else       in_valid = 1'b0;
      if (!busy && k < 4) k++;
      #1;
      chk($sformatf("busy mirror c%0d", c), 32'(out_busy), 32'(busy));
      if (c == 2) snap = all_out();
      if (c >= 3 && c <= 5) chk($sformatf("stall frozen c%0d", c), all_out(), snap);
      if (out_valid && !busy) begin
        got_exp.push_back(out_exp);
        got_fract.push_back(out_fract);
      end
    end
    busy = 1'b0;
    chk("stall beat count", 32'(got_exp.size()), 32'd4);
    for (int b = 0; b < 4 && b < got_exp.size(); b++) begin
      chk($sformatf("stall beat%0d exp", b),   32'(got_exp[b]),   32'(13'h11 + b));
      chk($sformatf("stall beat%0d fract", b), 32'(got_fract[b]), 32'(8'h80 + b));
    end

    // Synchronous clear with two beats in flight, applied while stalled.
    @(negedge clk); drive(1, 0, 13'h0200, 16'h8000, 2'd0, 6'h11);
    @(negedge clk); drive(1, 1, 13'h0300, 16'hC000, 2'd0, 6'h22);
    @(negedge clk); in_valid = 1'b0; busy = 1'b1;
    chk("pre-clear beat visible", 32'(out_valid), 32'h1);
    @(negedge clk); sync_rst = 1'b1;
    @(negedge clk);
    chk("sync clear outputs", all_out(), 32'h0);
    sync_rst = 1'b0; busy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("discarded beat c%0d", c), 32'(out_valid), 32'h0);
    end

    // Asynchronous reset between clock edges.
    @(negedge clk); drive(1, 1, 13'h0042, 16'h8000, 2'd0, 6'h3F);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    chk("async pre valid", 32'(out_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outputs", all_out(), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
